ecc_tpram_scrub: RTL

Single-clock, parametrised SECDED-protected two-port RAM with a background scrubber, collision forwarding and error logging. It replaces per-size fixed RAM wrappers in FIFO and buffer datapaths. The scrubber walks the array, writes single-bit corrections back, and keeps error counters and the last failing address.

---
 rtl/ecc_tpram_scrub.sv | 305 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/ecc_tpram_scrub.sv
// ecc_tpram_scrub: SECDED-protected two-port RAM with a background scrubber.
//
// Ports:
//   clk, rst                 single clock, synchronous active-high reset
//   wr_en/wr_addr/wr_data    user write (codeword XORed with inj_mask)
//   rd_en/rd_addr            user read request; result after 1+OUT_REG cycles
//   rd_vld/rd_data           read result and valid pulse
//   rd_sbe/rd_dbe            corrected single-bit / detected double-bit error
//   bypass_ecc               store zero parity, return raw data, no flags
//   inj_mask                 error injection mask applied on user writes
//   scrub_en/scrub_gap       scrubber enable and idle cycles between cells
//   scrub_busy/scrub_done    scrubber active / one-cycle end-of-pass pulse
//   err_clr                  clears counters and error log
//   sbe_cnt/dbe_cnt          saturating error counters
//   err_addr/err_scrub       address and source of the last error
module ecc_tpram_scrub #(
    parameter int unsigned ADDR_WIDTH   = 5,
    parameter int unsigned DATA_WIDTH   = 64,
    parameter int unsigned PARITY_WIDTH = 8,
    parameter int unsigned OUT_REG      = 1,
    parameter int unsigned CNT_WIDTH    = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 wr_en,
    input  logic [ADDR_WIDTH-1:0]                wr_addr,
    input  logic [DATA_WIDTH-1:0]                wr_data,
    input  logic                                 rd_en,
    input  logic [ADDR_WIDTH-1:0]                rd_addr,
    output logic                                 rd_vld,
    output logic [DATA_WIDTH-1:0]                rd_data,
    output logic                                 rd_sbe,
    output logic                                 rd_dbe,
    input  logic                                 bypass_ecc,
    input  logic [DATA_WIDTH+PARITY_WIDTH-1:0]   inj_mask,
    input  logic                                 scrub_en,
    input  logic [15:0]                          scrub_gap,
    output logic                                 scrub_busy,
    output logic                                 scrub_done,
    input  logic                                 err_clr,
    output logic [CNT_WIDTH-1:0]                 sbe_cnt,
    output logic [CNT_WIDTH-1:0]                 dbe_cnt,
    output logic [ADDR_WIDTH-1:0]                err_addr,
    output logic                                 err_scrub
);

    localparam int unsigned RAM_DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned CW        = DATA_WIDTH + PARITY_WIDTH;
    localparam int unsigned HB        = PARITY_WIDTH - 1;  // Hamming check bits

    typedef logic [DATA_WIDTH-1:0][HB-1:0] pos_tab_t;
    typedef logic [HB-1:0][DATA_WIDTH-1:0] mask_tab_t;

    // Hamming position of each data bit: the non-power-of-two positions in order.
    function automatic pos_tab_t build_pos();
        pos_tab_t    tab;
        int unsigned idx;
        tab = '0;
        idx = 0;
        for (int unsigned p = 1; p < CW; p++) begin
            if ((p & (p - 1)) != 0 && idx < DATA_WIDTH) begin
                tab[idx] = HB'(p);
                idx++;
            end
        end
        return tab;
    endfunction

    function automatic mask_tab_t build_mask(input pos_tab_t pos);
        mask_tab_t m;
        m = '0;
        for (int unsigned j = 0; j < HB; j++) begin
            for (int unsigned i = 0; i < DATA_WIDTH; i++) m[j][i] = pos[i][j];
        end
        return m;
    endfunction

    localparam pos_tab_t  POS  = build_pos();
    localparam mask_tab_t MASK = build_mask(POS);

    // Codeword is {parity, data}; top parity bit is overall parity.
    function automatic logic [CW-1:0] ecc_encode(input logic [DATA_WIDTH-1:0] d);
        logic [PARITY_WIDTH-1:0] p;
        p = '0;
        for (int unsigned j = 0; j < HB; j++) p[j] = ^(d & MASK[j]);
        p[HB] = ^{p[HB-1:0], d};
        return {p, d};
    endfunction

    function automatic logic [CNT_WIDTH-1:0] cnt_next(input logic [CNT_WIDTH-1:0] c,
                                                      input logic inc, input logic clr);
        if (clr) return inc ? CNT_WIDTH'(1) : '0;
        if (inc && c != '1) return c + 1'b1;
        return c;
    endfunction

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StGap   = 3'd1;
    localparam logic [2:0] StRead  = 3'd2;
    localparam logic [2:0] StCheck = 3'd3;
    localparam logic [2:0] StFix   = 3'd4;

    logic [CW-1:0]         mem [RAM_DEPTH];
    logic [CW-1:0]         wr_cw;
    logic                  col, scrub_rd, scrub_wr, next_cell, wr_hit;
    logic [ADDR_WIDTH-1:0] rd_a;

    logic                  s1_vld, s1_user, s1_raw;
    logic [ADDR_WIDTH-1:0] s1_addr;
    logic [CW-1:0]         s1_cw;

    logic [HB-1:0]         syn;
    logic                  ovr, dec_sbe, dec_dbe;
    logic [DATA_WIDTH-1:0] dec_data;

    logic                  f_vld, f_user, f_sbe, f_dbe;
    logic [ADDR_WIDTH-1:0] f_addr;
    logic [DATA_WIDTH-1:0] f_data;

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] saddr_q, saddr_d;
    logic [15:0]           gap_q, gap_d;
    logic                  drop_q, drop_d, done_q, done_d;
    logic [CW-1:0]         fix_q, fix_d;

    assign wr_cw  = (bypass_ecc ? {{PARITY_WIDTH{1'b0}}, wr_data} : ecc_encode(wr_data)) ^ inj_mask;
    assign col    = rd_en & wr_en & (rd_addr == wr_addr);
    assign rd_a   = rd_en ? rd_addr : saddr_q;
    assign wr_hit = wr_en & (wr_addr == saddr_q);

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_cw;
        else if (scrub_wr) mem[saddr_q] <= fix_q;
    end

    // Stage 1: array read; collisions forward the unmasked write data as raw.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld  <= 1'b0;
            s1_user <= 1'b0;
            s1_raw  <= 1'b0;
            s1_addr <= '0;
            s1_cw   <= '0;
        end else begin
            s1_vld  <= rd_en | scrub_rd;
            s1_user <= rd_en;
            if (rd_en | scrub_rd) begin
                s1_addr <= rd_a;
                s1_raw  <= bypass_ecc | col;
                s1_cw   <= col ? {{PARITY_WIDTH{1'b0}}, wr_data} : mem[rd_a];
            end
        end
    end

    always_comb begin
        syn = '0;
        for (int unsigned j = 0; j < HB; j++) begin
            syn[j] = s1_cw[DATA_WIDTH+j] ^ (^(s1_cw[DATA_WIDTH-1:0] & MASK[j]));
        end
        ovr      = ^s1_cw;
        dec_data = s1_cw[DATA_WIDTH-1:0];
        if (!s1_raw) begin
            for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
                if (ovr && syn == POS[i]) dec_data[i] = ~s1_cw[i];
            end
        end
        dec_sbe = ovr & ~s1_raw;
        dec_dbe = ~ovr & (syn != '0) & ~s1_raw;
    end

    if (OUT_REG != 0) begin : g_oreg
        always_ff @(posedge clk) begin
            if (rst) begin
                f_vld  <= 1'b0;
                f_user <= 1'b0;
                f_sbe  <= 1'b0;
                f_dbe  <= 1'b0;
                f_addr <= '0;
                f_data <= '0;
            end else begin
                f_vld  <= s1_vld;
                f_user <= s1_user;
                f_sbe  <= s1_vld & dec_sbe;
                f_dbe  <= s1_vld & dec_dbe;
                f_addr <= s1_addr;
                f_data <= dec_data;
            end
        end
    end else begin : g_noreg
        assign f_vld  = s1_vld;
        assign f_user = s1_user;
        assign f_sbe  = s1_vld & dec_sbe;
        assign f_dbe  = s1_vld & dec_dbe;
        assign f_addr = s1_addr;
        assign f_data = dec_data;
    end

    assign rd_vld  = f_vld & f_user;
    assign rd_data = f_data;
    assign rd_sbe  = f_vld & f_user & f_sbe;
    assign rd_dbe  = f_vld & f_user & f_dbe;

    // One shared read port, so user and scrub results never land together.
    always_ff @(posedge clk) begin
        if (rst) begin
            sbe_cnt   <= '0;
            dbe_cnt   <= '0;
            err_addr  <= '0;
            err_scrub <= 1'b0;
        end else begin
            sbe_cnt <= cnt_next(sbe_cnt, f_vld & f_sbe, err_clr);
            dbe_cnt <= cnt_next(dbe_cnt, f_vld & f_dbe, err_clr);
            if (f_vld && (f_sbe || f_dbe)) begin
                err_addr  <= f_addr;
                err_scrub <= ~f_user;
            end else if (err_clr) begin
                err_addr  <= '0;
                err_scrub <= 1'b0;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        saddr_d   = saddr_q;
        gap_d     = gap_q;
        drop_d    = drop_q;
        fix_d     = fix_q;
        done_d    = 1'b0;
        scrub_rd  = 1'b0;
        scrub_wr  = 1'b0;
        next_cell = 1'b0;
        case (state_q)
            StIdle: begin
                if (scrub_en) begin
                    saddr_d = '0;
                    gap_d   = scrub_gap;
                    state_d = (scrub_gap == 16'd0) ? StRead : StGap;
                end
            end
            StGap: begin
                if (gap_q <= 16'd1) state_d = StRead;
                else gap_d = gap_q - 16'd1;
            end
            StRead: begin
                if (!rd_en) begin
                    scrub_rd = 1'b1;
                    drop_d   = wr_hit;  // same-cycle user write makes the read stale
                    state_d  = StCheck;
                end
            end
            StCheck: begin
                if (wr_hit) drop_d = 1'b1;
                if (f_vld && !f_user) begin
                    if (f_sbe) begin
                        fix_d   = ecc_encode(f_data);
                        state_d = StFix;
                    end else begin
                        next_cell = 1'b1;
                    end
                end
            end
            StFix: begin
                if (drop_q) begin
                    next_cell = 1'b1;
                end else if (!wr_en) begin
                    scrub_wr  = 1'b1;
                    next_cell = 1'b1;
                end else if (wr_hit) begin
                    drop_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        if (next_cell) begin
            saddr_d = saddr_q + 1'b1;
            done_d  = &saddr_q;
            gap_d   = scrub_gap;
            if (!scrub_en) state_d = StIdle;
            else state_d = (scrub_gap == 16'd0) ? StRead : StGap;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            saddr_q <= '0;
            gap_q   <= '0;
            drop_q  <= 1'b0;
            done_q  <= 1'b0;
            fix_q   <= '0;
        end else begin
            state_q <= state_d;
            saddr_q <= saddr_d;
            gap_q   <= gap_d;
            drop_q  <= drop_d;
            done_q  <= done_d;
            fix_q   <= fix_d;
        end
    end

    assign scrub_busy = (state_q != StIdle);
    assign scrub_done = done_q;

endmodule
